// File: rtl/display_scheduler.sv
// Two-requester display scheduler driving a four-digit multiplexed
// seven-segment display. A free-running prescaler produces scan ticks that
// rotate through the digits; an arbiter grants the display to requester A or
// B, captures its four BCD digits into a shadow register, and holds them on
// screen for HOLD_TICKS scan ticks before serving the next request.
module display_scheduler #(
   parameter int CLK_DIV    = 50000,
   parameter int HOLD_TICKS = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a,
   input  logic [15:0] data_a,
   input  logic        req_b,
   input  logic [15:0] data_b,
   output logic        ack_a,
   output logic        ack_b,
   output logic [3:0]  bcd,
   output logic [3:0]  an,
   output logic [1:0]  active_src,
   output logic        busy
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHOW_A = 2'd1,
      SHOW_B = 2'd2
   } state_t;

   state_t          state_q,  state_d;
   logic [PW-1:0]   presc_q,  presc_d;
   logic [1:0]      idx_q,    idx_d;
   logic [HW-1:0]   hold_q,   hold_d;
   logic [15:0]     shadow_q, shadow_d;
   logic            valid_q,  valid_d;
   logic            last_b_q, last_b_d;   // 1: B was granted most recently
   logic            ack_a_q,  ack_a_d;
   logic            ack_b_q,  ack_b_d;

   logic            tick;
   logic            grant_a;
   logic            grant_b;

   assign tick = (presc_q == PRESC_MAX);

   // Next-state logic for the scan counters, arbiter FSM and captured message.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned; a missed branch would otherwise infer a latch.
      state_d  = state_q;
      presc_d  = tick ? '0 : presc_q + 1'b1;
      idx_d    = tick ? idx_q + 2'd1 : idx_q;
      hold_d   = hold_q;
      shadow_d = shadow_q;
      valid_d  = valid_q;
      last_b_d = last_b_q;
      ack_a_d  = 1'b0;
      ack_b_d  = 1'b0;
      // On a conflict the requester not granted last time wins.
      grant_a  = req_a && (!req_b || last_b_q);
      grant_b  = req_b && (!req_a || !last_b_q);

      case (state_q)
         IDLE: begin
            if (grant_a) begin
               state_d  = SHOW_A;
               shadow_d = data_a;
               valid_d  = 1'b1;
               hold_d   = '0;
               last_b_d = 1'b0;
               ack_a_d  = 1'b1;
            end else if (grant_b) begin
               state_d  = SHOW_B;
               shadow_d = data_b;
               valid_d  = 1'b1;
               hold_d   = '0;
               last_b_d = 1'b1;
               ack_b_d  = 1'b1;
            end
         end
         SHOW_A, SHOW_B: begin
            // Requests are ignored here; the hold expires on a scan tick.
            if (tick) begin
               if (hold_q == HOLD_MAX) begin
                  state_d = IDLE;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous, active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q  <= IDLE;
         presc_q  <= '0;
         idx_q    <= '0;
         hold_q   <= '0;
         // NOTE: the shadow register is cleared as well, so the digits seen
         // after reset never depend on power-up contents.
         shadow_q <= '0;
         valid_q  <= 1'b0;
         last_b_q <= 1'b1;
         ack_a_q  <= 1'b0;
         ack_b_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         hold_q   <= hold_d;
         shadow_q <= shadow_d;
         valid_q  <= valid_d;
         last_b_q <= last_b_d;
         ack_a_q  <= ack_a_d;
         ack_b_q  <= ack_b_d;
      end
   end

   // Digit decode from the registered index, shadow register and valid flag.
   always_comb begin
      an  = 4'b1111;
      bcd = 4'h0;
      if (valid_q) begin
         case (idx_q)
            2'd0: begin an = 4'b1110; bcd = shadow_q[3:0];   end
            2'd1: begin an = 4'b1101; bcd = shadow_q[7:4];   end
            2'd2: begin an = 4'b1011; bcd = shadow_q[11:8];  end
            default: begin an = 4'b0111; bcd = shadow_q[15:12]; end
         endcase
      end
   end

   // Status outputs derived from the FSM state.
   always_comb begin
      busy       = (state_q == SHOW_A) || (state_q == SHOW_B);
      active_src = 2'b00;
      if (state_q == SHOW_A) active_src = 2'b01;
      if (state_q == SHOW_B) active_src = 2'b10;
   end

   assign ack_a = ack_a_q;
   assign ack_b = ack_b_q;

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 50000, giving system clocks per digit-scan tick (legal range >= 2).
REQ-002 The module SHALL have parameter HOLD_TICKS, default 1000, giving scan ticks a granted message stays displayed (legal range >= 1).
REQ-003 The module SHALL have port clk, input, width 1: the single system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-005 The module SHALL have port req_a, input, width 1: requester A wants the display; held high until ack_a.
REQ-006 The module SHALL have port data_a, input, width 16: requester A's four BCD digits; digit0 = [3:0], digit3 = [15:12].
REQ-007 The module SHALL have port req_b, input, width 1: same as req_a, for requester B.
REQ-008 The module SHALL have port data_b, input, width 16: same as data_a, for requester B.
REQ-009 The module SHALL have port ack_a, output, width 1: one-cycle pulse; data_a has been captured.
REQ-010 The module SHALL have port ack_b, output, width 1: one-cycle pulse; data_b has been captured.
REQ-011 The module SHALL have port bcd, output, width 4: nibble for the currently scanned digit, to the BCD-to-segment decoder.
REQ-012 The module SHALL have port an, output, width 4: active-low digit enables, exactly one low while displaying.
REQ-013 The module SHALL have port active_src, output, width 2: 00 none, 01 A, 10 B holds the display.
REQ-014 The module SHALL have port busy, output, width 1: high in SHOW_A or SHOW_B.

Function
REQ-015 The prescaler SHALL count 0..CLK_DIV-1, wrap to 0, and assert an internal tick for one cycle when it equals CLK_DIV-1.
REQ-016 The 2-bit digit index SHALL increment on each tick, wrapping 3->0.
REQ-017 The mapping SHALL be: index 0 -> an=1110, bcd=shadow[3:0]; index 1 -> 1101, [7:4]; index 2 -> 1011, [11:8]; index 3 -> 0111, [15:12].
REQ-018 an and bcd SHALL be combinational decodes of the registered index, shadow register and valid flag only.
REQ-019 While valid=0, an SHALL be 1111 and bcd SHALL be 0000.
REQ-020 The FSM SHALL have states IDLE, SHOW_A and SHOW_B.
REQ-021 In IDLE with only req_a high, the block SHALL go to SHOW_A, load shadow<=data_a and set valid<=1.
REQ-022 In IDLE with only req_b high, the block SHALL do the same with B, going to SHOW_B.
REQ-023 In IDLE with both requests high, the block SHALL grant the requester not granted most recently; the last-granted pointer SHALL reset to B so that A wins first.
REQ-024 The ack SHALL be a registered pulse, high exactly in the first cycle of SHOW_x, one cycle after the capture edge.
REQ-025 A request dropped before its ack SHALL cause no capture and no ack.
REQ-026 In SHOW_x, a hold counter SHALL increment on each tick and be cleared on grant.
REQ-027 On a tick with hold count = HOLD_TICKS-1, the FSM SHALL return to IDLE.
REQ-028 Requests SHALL be ignored (not acked) in SHOW_x and are served only from IDLE.
REQ-029 Minimum gap SHALL be one IDLE cycle between the end of one hold and the next grant.
REQ-030 In IDLE, the shadow register SHALL keep the last message, and scanning SHALL continue on the last message.
REQ-031 active_src SHALL be 00 in IDLE.
REQ-032 The prescaler and digit index SHALL run freely and SHALL NOT be reset on a grant.

Reset
REQ-033 While rst=1 at a clock edge, the block SHALL set: state IDLE, prescaler 0, index 0, hold count 0, shadow 0, valid 0, pointer B, ack_a=ack_b=0, an=1111, bcd=0000, active_src=00, busy=0.
REQ-034 Reset SHALL take priority over all other events, including mid-SHOW; a pending ack SHALL be suppressed.
REQ-035 After reset is released, the first tick SHALL occur CLK_DIV cycles later.

Verification (CLK_DIV=4, HOLD_TICKS=2)
REQ-036 Bench SHALL cover: reset, then req_a=1 with data_a=16'h4321 -> ack_a high in the 2nd cycle after req_a is sampled, busy=1, active_src=01, and an/bcd cycling 1110/1, 1101/2, 1011/3, 0111/4 every 4 clocks.
REQ-037 Bench SHALL cover: req_a and req_b both held high from reset -> A is granted first; after 2 ticks, one IDLE cycle, then B is granted; next conflict grants A.
REQ-038 Bench SHALL cover: req_b asserted during SHOW_A -> no ack_b until SHOW_A ends; ack_b follows the IDLE cycle.
REQ-039 Bench SHALL cover: a 1-cycle req_a pulse while busy -> no ack_a, and the shadow is unchanged.
REQ-040 Bench SHALL cover: rst asserted mid-SHOW_B -> next cycle an=1111, busy=0, active_src=00, no ack_b, valid=0.
REQ-041 Bench SHALL cover: index at 3 on a tick -> wraps to 0 with an=1110.
